// File: rtl/aes_sbox_sched_pkg.sv
// Shared types and constants for the masked S-box batch scheduler.
package aes_sbox_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef enum logic {REQ_ST = 1'b0, REQ_KY = 1'b1} req_t;

  localparam int N_ST       = 16;
  localparam int N_KY       = 4;
  localparam int DEF_SHARES = 2;
  localparam int BYTE_W     = 8 * DEF_SHARES;
  localparam int IDX_W      = 5;
endpackage

// File: rtl/aes_sbox_sched_tracker.sv
// Follows issued bytes through the fixed S-box latency and names the
// result slot that the current S-box output belongs to.
module sbox_valid_tracker
  import aes_sbox_sched_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic             ClkxCI,
  input  logic             RstxBI,
  input  logic             ClearxSI,
  input  logic             PushxSI,
  output logic             CapxSO,
  output logic [IDX_W-1:0] IdxxDO
);
  logic [LATENCY-1:0] r_valid;
  logic [IDX_W-1:0]   r_idx;

  assign CapxSO = r_valid[LATENCY-1];
  assign IdxxDO = r_idx;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_valid <= '0;
      r_idx   <= '0;
    end else begin
      r_valid <= (r_valid << 1) | LATENCY'(PushxSI);
      if (ClearxSI)
        r_idx <= '0;
      else if (CapxSO)
        r_idx <= r_idx + 1'b1;
    end
  end
endmodule

// File: rtl/aes_sbox_sched.sv
// Shares one pipelined masked S-box between the round datapath (16 bytes)
// and the key schedule (4 bytes), one whole batch at a time.
module aes_sbox_sched
  import aes_sbox_sched_pkg::*;
#(
  parameter int SHARES  = DEF_SHARES,
  parameter int LATENCY = 4,
  parameter int RND_W   = 36
) (
  input  logic                       ClkxCI,
  input  logic                       RstxBI,
  input  logic                       StReqxSI,
  input  logic [N_ST*8*SHARES-1:0]   StDataxDI,
  output logic                       StAckxSO,
  output logic [N_ST*8*SHARES-1:0]   StResxDO,
  output logic                       StDonexSO,
  input  logic                       KyReqxSI,
  input  logic [N_KY*8*SHARES-1:0]   KyDataxDI,
  output logic                       KyAckxSO,
  output logic [N_KY*8*SHARES-1:0]   KyResxDO,
  output logic                       KyDonexSO,
  input  logic                       RndValidxSI,
  input  logic [RND_W-1:0]           RndxDI,
  output logic                       RndReadyxSO,
  output logic [8*SHARES-1:0]        SboxInxDO,
  output logic [RND_W-1:0]           SboxRndxDO,
  input  logic [8*SHARES-1:0]        SboxOutxDI,
  output logic                       BusyxSO
);
  localparam int BW = 8 * SHARES;

  state_t              r_state;
  req_t                r_grant;
  req_t                r_last;
  logic [N_ST*BW-1:0]  r_batch;
  logic [N_ST*BW-1:0]  r_resBuf;
  logic [IDX_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_n;
  logic                r_stAck, r_kyAck, r_stDone, r_kyDone;
  logic [N_ST*BW-1:0]  r_stRes;
  logic [N_KY*BW-1:0]  r_kyRes;
  logic [BW-1:0]       r_sboxIn;
  logic [RND_W-1:0]    r_sboxRnd;

  logic                w_cap;
  logic [IDX_W-1:0]    w_idx;
  logic                w_start, w_grantKy, w_push, w_lastCap;
  logic [N_ST*BW-1:0]  w_resFinal;

  // Key wins a tie only when the datapath owned the previous batch.
  always_comb begin
    w_grantKy  = KyReqxSI && (!StReqxSI || (r_last == REQ_ST));
    w_start    = (r_state == IDLE) && (StReqxSI || KyReqxSI);
    w_push     = (r_state == ISSUE) && RndValidxSI;
    w_lastCap  = (r_state == DRAIN) && w_cap && (w_idx == r_n - 1'b1);
    w_resFinal = r_resBuf;
    if (w_cap)
      w_resFinal[int'(w_idx)*BW +: BW] = SboxOutxDI;
  end

  sbox_valid_tracker #(.LATENCY(LATENCY)) u_tracker (
    .ClkxCI   (ClkxCI),
    .RstxBI   (RstxBI),
    .ClearxSI (w_start),
    .PushxSI  (w_push),
    .CapxSO   (w_cap),
    .IdxxDO   (w_idx)
  );

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_state   <= IDLE;
      r_grant   <= REQ_ST;
      r_last    <= REQ_KY;
      r_batch   <= '0;
      r_resBuf  <= '0;
      r_cnt     <= '0;
      r_n       <= '0;
      r_stAck   <= 1'b0;
      r_kyAck   <= 1'b0;
      r_stDone  <= 1'b0;
      r_kyDone  <= 1'b0;
      r_stRes   <= '0;
      r_kyRes   <= '0;
      r_sboxIn  <= '0;
      r_sboxRnd <= '0;
    end else begin
      r_stAck  <= 1'b0;
      r_kyAck  <= 1'b0;
      r_stDone <= 1'b0;
      r_kyDone <= 1'b0;
      if (w_cap)
        r_resBuf[int'(w_idx)*BW +: BW] <= SboxOutxDI;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= ISSUE;
            r_cnt   <= '0;
            if (w_grantKy) begin
              r_kyAck <= 1'b1;
              r_grant <= REQ_KY;
              r_last  <= REQ_KY;
              r_n     <= IDX_W'(N_KY);
              r_batch <= (N_ST*BW)'(KyDataxDI);
            end else begin
              r_stAck <= 1'b1;
              r_grant <= REQ_ST;
              r_last  <= REQ_ST;
              r_n     <= IDX_W'(N_ST);
              r_batch <= StDataxDI;
            end
          end
        end
        // Shares only move when a fresh random word arrives, so stalls add no toggles.
        ISSUE: begin
          if (RndValidxSI) begin
            r_sboxIn  <= r_batch[int'(r_cnt)*BW +: BW];
            r_sboxRnd <= RndxDI;
            r_cnt     <= r_cnt + 1'b1;
            if (r_cnt == r_n - 1'b1)
              r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_lastCap) begin
            r_state <= IDLE;
            if (r_grant == REQ_KY) begin
              r_kyRes  <= w_resFinal[N_KY*BW-1:0];
              r_kyDone <= 1'b1;
            end else begin
              r_stRes  <= w_resFinal;
              r_stDone <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign StAckxSO    = r_stAck;
  assign KyAckxSO    = r_kyAck;
  assign StDonexSO   = r_stDone;
  assign KyDonexSO   = r_kyDone;
  assign StResxDO    = r_stRes;
  assign KyResxDO    = r_kyRes;
  assign SboxInxDO   = r_sboxIn;
  assign SboxRndxDO  = r_sboxRnd;
  assign RndReadyxSO = w_push;
  assign BusyxSO     = (r_state != IDLE);
endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched with a behavioural 4-cycle masked S-box
// and per-requester scoreboards of expected unmasked results.
module tb_aes_sbox_sched;
  localparam int SHARES  = 2;
  localparam int LATENCY = 4;
  localparam int RND_W   = 36;
  localparam int BW      = 8 * SHARES;

  logic               ClkxCI = 1'b0;
  logic               RstxBI;
  logic               StReqxSI, KyReqxSI;
  logic [16*BW-1:0]   StDataxDI, StResxDO;
  logic [4*BW-1:0]    KyDataxDI, KyResxDO;
  logic               StAckxSO, StDonexSO, KyAckxSO, KyDonexSO;
  logic               RndValidxSI, RndReadyxSO, BusyxSO;
  logic [RND_W-1:0]   RndxDI, SboxRndxDO;
  logic [BW-1:0]      SboxInxDO, SboxOutxDI;

  int nTests = 0;
  int nFail  = 0;
  int rndMode = 0;
  bit lastKy = 1'b1;
  logic [7:0] stQ[$];
  logic [7:0] kyQ[$];
  logic [7:0] stPlain[16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
  logic [7:0] stExp[16]   = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
                              8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};
  logic [7:0] kyPlain[4]  = '{8'h53, 8'h00, 8'hFF, 8'h01};
  logic [7:0] kyExp[4]    = '{8'hED, 8'h63, 8'h16, 8'h7C};

  aes_sbox_sched #(.SHARES(SHARES), .LATENCY(LATENCY), .RND_W(RND_W)) dut (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI),
    .StReqxSI(StReqxSI), .StDataxDI(StDataxDI), .StAckxSO(StAckxSO),
    .StResxDO(StResxDO), .StDonexSO(StDonexSO),
    .KyReqxSI(KyReqxSI), .KyDataxDI(KyDataxDI), .KyAckxSO(KyAckxSO),
    .KyResxDO(KyResxDO), .KyDonexSO(KyDonexSO),
    .RndValidxSI(RndValidxSI), .RndxDI(RndxDI), .RndReadyxSO(RndReadyxSO),
    .SboxInxDO(SboxInxDO), .SboxRndxDO(SboxRndxDO), .SboxOutxDI(SboxOutxDI),
    .BusyxSO(BusyxSO)
  );

  initial forever #5 ClkxCI = ~ClkxCI;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sboxRef(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Masked S-box model: output mask taken from the fresh randomness.
  initial begin
    logic [BW-1:0] q0, q1, q2;
    logic [7:0] mOut;
    q0 = '0; q1 = '0; q2 = '0;
    SboxOutxDI = '0;
    forever begin
      @(posedge ClkxCI); #1;
      SboxOutxDI = q2;
      q2 = q1;
      q1 = q0;
      mOut = SboxRndxDO[7:0];
      q0 = {mOut, sboxRef(SboxInxDO[7:0] ^ SboxInxDO[15:8]) ^ mOut};
    end
  end

  initial begin
    logic [63:0] r64;
    int patPos = 0;
    RndValidxSI = 1'b1;
    RndxDI = '0;
    forever begin
      @(posedge ClkxCI); #1;
      r64 = {$urandom, $urandom};
      RndxDI = r64[RND_W-1:0];
      RndValidxSI = (rndMode == 0) ? 1'b1 : ((patPos % 3) == 0);
      patPos++;
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nTests++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit isKey);
    logic [7:0] m;
    for (int k = 0; k < (isKey ? 4 : 16); k++) begin
      m = 8'($urandom);
      if (isKey) begin
        KyDataxDI[k*BW +: BW] = {m, kyPlain[k] ^ m};
        kyQ.push_back(kyExp[k]);
      end else begin
        StDataxDI[k*BW +: BW] = {m, stPlain[k] ^ m};
        stQ.push_back(stExp[k]);
      end
    end
  endtask

  task automatic waitBatch(input bit isKey, input bit kyInDrain, output bit kyEarly);
    int n = isKey ? 4 : 16;
    int t = 0, k = 0, issued = 0, lastK = -1, doneK = -1, xfer = 0;
    bit v, r, otherDone = 1'b0;
    logic [BW-1:0] prevIn;
    logic [16*BW-1:0] otherRes;
    logic [BW-1:0] sh;
    logic [7:0] e;
    kyEarly = 1'b0;
    while (!(isKey ? KyAckxSO : StAckxSO) && t < 50) begin
      @(negedge ClkxCI); t++;
    end
    checkOutput(isKey ? "ky_ack" : "st_ack", isKey ? KyAckxSO : StAckxSO, 1);
    lastKy = isKey;
    if (isKey) KyReqxSI = 1'b0; else StReqxSI = 1'b0;
    otherRes = isKey ? StResxDO : (16*BW)'(KyResxDO);
    while (k < 300) begin
      v = RndValidxSI;
      r = RndReadyxSO;
      prevIn = SboxInxDO;
      @(negedge ClkxCI); k++;
      if (!v && issued < n && rndMode != 0)
        checkOutput("stall_hold", SboxInxDO, prevIn);
      if (v && issued < n) begin
        issued++;
        if (issued == n) lastK = k;
      end
      if (v && r) xfer++;
      if (isKey ? StDonexSO : KyDonexSO) otherDone = 1'b1;
      if (kyInDrain && KyAckxSO) kyEarly = 1'b1;
      if (kyInDrain && issued == n) KyReqxSI = 1'b1;
      if (isKey ? KyDonexSO : StDonexSO) begin
        doneK = k;
        break;
      end
    end
    checkOutput("done_latency", doneK, lastK + LATENCY);
    checkOutput("rnd_transfers", xfer, n);
    checkOutput("other_done_quiet", otherDone, 0);
    checkOutput("other_res_kept", isKey ? StResxDO : (16*BW)'(KyResxDO), otherRes);
    for (int b = 0; b < n; b++) begin
      sh = isKey ? KyResxDO[b*BW +: BW] : StResxDO[b*BW +: BW];
      e  = isKey ? ((kyQ.size() > 0) ? kyQ.pop_front() : 8'hXX)
                 : ((stQ.size() > 0) ? stQ.pop_front() : 8'hXX);
      checkOutput($sformatf("%s_res[%0d]", isKey ? "ky" : "st", b), sh[7:0] ^ sh[15:8], e);
    end
    @(negedge ClkxCI);
    checkOutput("done_one_cycle", isKey ? KyDonexSO : StDonexSO, 0);
  endtask

  initial begin
    bit early;
    int t;
    RstxBI = 1'b0;
    StReqxSI = 1'b0; KyReqxSI = 1'b0;
    StDataxDI = '0; KyDataxDI = '0;
    repeat (2) @(negedge ClkxCI);
    checkOutput("reset_ctrl", {StAckxSO, KyAckxSO, StDonexSO, KyDonexSO, BusyxSO, RndReadyxSO}, 0);
    checkOutput("reset_sboxin", SboxInxDO, 0);
    checkOutput("reset_sboxrnd", SboxRndxDO, 0);
    checkOutput("reset_stres", StResxDO, 0);
    checkOutput("reset_kyres", KyResxDO, 0);
    RstxBI = 1'b1;
    @(negedge ClkxCI);

    $display("[TB] key batch");
    applyStimulus(1'b1);
    KyReqxSI = 1'b1;
    waitBatch(1'b1, 1'b0, early);

    $display("[TB] datapath batch");
    applyStimulus(1'b0);
    StReqxSI = 1'b1;
    waitBatch(1'b0, 1'b0, early);

    $display("[TB] simultaneous requests");
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    StReqxSI = 1'b1; KyReqxSI = 1'b1;
    t = 0;
    while (!StAckxSO && !KyAckxSO && t < 50) begin
      @(negedge ClkxCI); t++;
    end
    checkOutput("arb_first", {KyAckxSO, StAckxSO}, lastKy ? 2'b01 : 2'b10);
    waitBatch(!lastKy, 1'b0, early);
    waitBatch(!lastKy, 1'b0, early);

    $display("[TB] randomness stalls");
    rndMode = 1;
    applyStimulus(1'b0);
    StReqxSI = 1'b1;
    waitBatch(1'b0, 1'b0, early);
    rndMode = 0;

    $display("[TB] reset mid-batch");
    applyStimulus(1'b0);
    StReqxSI = 1'b1;
    t = 0;
    while (!StAckxSO && t < 50) begin
      @(negedge ClkxCI); t++;
    end
    StReqxSI = 1'b0;
    repeat (7) @(negedge ClkxCI);
    #2 RstxBI = 1'b0;
    #1;
    checkOutput("midreset_ctrl", {StAckxSO, KyAckxSO, StDonexSO, KyDonexSO, BusyxSO, RndReadyxSO}, 0);
    checkOutput("midreset_sboxin", SboxInxDO, 0);
    checkOutput("midreset_sboxrnd", SboxRndxDO, 0);
    checkOutput("midreset_stres", StResxDO, 0);
    checkOutput("midreset_kyres", KyResxDO, 0);
    @(negedge ClkxCI);
    RstxBI = 1'b1;
    stQ.delete();
    lastKy = 1'b1;
    early = 1'b0;
    repeat (30) begin
      @(negedge ClkxCI);
      if (StDonexSO || BusyxSO) early = 1'b1;
    end
    checkOutput("abandoned_no_done", early, 0);
    applyStimulus(1'b0);
    StReqxSI = 1'b1;
    waitBatch(1'b0, 1'b0, early);

    $display("[TB] key request during drain");
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    StReqxSI = 1'b1;
    waitBatch(1'b0, 1'b1, early);
    checkOutput("ky_ack_not_early", early, 0);
    checkOutput("ky_ack_after_done", KyAckxSO, 1);
    waitBatch(1'b1, 1'b0, early);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
